// File: rtl/gpc_dmem_mmio_arb_pkg.sv
// Shared types for the gpc data-memory / MMIO wrapper: region and port tags,
// the request bundle and the byte-enable merge used by every writable word.
package gpc_dmem_mmio_arb_pkg;

  typedef enum logic [1:0] {REG_DATA, REG_MMIO, REG_UNMAP} t_dmem_region;
  typedef enum logic {PORT_CORE, PORT_FAB} t_dmem_port;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } t_dmem_req;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/gpc_sram_sp_be.sv
// Single-port 32-bit SRAM with byte enables and a registered (1-cycle) read.
// Behavioural model by default; Altera altsyncram when ALTERA is defined.
module gpc_sram_sp_be #(
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clock,
  input  logic                     en,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              q
);

`ifdef ALTERA
  altsyncram #(
    .operation_mode                ("SINGLE_PORT"),
    .width_a                       (32),
    .widthad_a                     ($clog2(DEPTH)),
    .numwords_a                    (DEPTH),
    .width_byteena_a               (4),
    .outdata_reg_a                 ("UNREGISTERED"),
    .read_during_write_mode_port_a ("OLD_DATA"),
    .lpm_type                      ("altsyncram")
  ) u_ram (
    .clock0    (clock),
    .clocken0  (en),
    .wren_a    (we),
    .byteena_a (be),
    .address_a (addr),
    .data_a    (wdata),
    .q_a       (q)
  );
`else
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (en) begin
      if (we)
        for (int b = 0; b < 4; b++)
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      q <= mem[addr];
    end
  end
`endif

endmodule

// File: rtl/gpc_dmem_mmio_arb.sv
// Core/fabric shared access to data SRAM, CR bank and direct-out words.
// One grant per cycle, core-first with fabric anti-starvation; 1-cycle responses.
module gpc_dmem_mmio_arb
  import gpc_dmem_mmio_arb_pkg::*;
#(
  parameter int unsigned        DATA_DEPTH = 512,
  parameter logic [31:0]        DATA_BASE  = 32'h0000,
  parameter logic [31:0]        MMIO_BASE  = 32'h1000,
  parameter int unsigned        NUM_CR     = 8,
  parameter int unsigned        NUM_DRCT   = 2,
  parameter logic [NUM_CR*32-1:0] CR_RST_VAL = '0,
  parameter int unsigned        STARVE_MAX = 4
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   core_req,
  input  logic                   core_we,
  input  logic [3:0]             core_be,
  input  logic [31:0]            core_addr,
  input  logic [31:0]            core_wdata,
  output logic                   core_gnt,
  output logic                   core_rvalid,
  output logic [31:0]            core_rdata,
  output logic                   core_err,
  input  logic                   fab_req,
  input  logic                   fab_we,
  input  logic [3:0]             fab_be,
  input  logic [31:0]            fab_addr,
  input  logic [31:0]            fab_wdata,
  output logic                   fab_gnt,
  output logic                   fab_rvalid,
  output logic [31:0]            fab_rdata,
  output logic                   fab_err,
  output logic [NUM_CR*32-1:0]   cr_o,
  output logic [NUM_DRCT*32-1:0] drct_out_o
);

  localparam int unsigned AW         = $clog2(DATA_DEPTH);
  localparam int unsigned NUM_MMIO   = NUM_CR + NUM_DRCT;
  localparam int unsigned WCW        = $clog2(STARVE_MAX + 1);
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(STARVE_MAX);
  localparam logic [31:0] DATA_BYTES = 32'(DATA_DEPTH * 4);

  logic                          rst_d;
  logic [WCW-1:0]                wait_cnt;
  logic                          gnt_en, fab_pri, core_win, fab_win, gnt_any;
  t_dmem_req                     core_r, fab_r, sel;
  t_dmem_port                    sel_port;
  logic [31:0]                   addr_w, data_off;
  logic [29:0]                   mmio_word;
  logic                          data_hit, mmio_hit;
  t_dmem_region                  region;
  logic [NUM_CR-1:0][31:0]       cr_q;
  logic [NUM_DRCT-1:0][31:0]     drct_q;
  logic [31:0]                   mmio_rd;
  logic [31:0]                   sram_q;

  logic                          rvalid_q, rwe_q;
  t_dmem_port                    rport_q;
  t_dmem_region                  rregion_q;
  logic [31:0]                   mmio_q, rsp_data;
  logic                          rsp_live;

  assign core_r = '{we: core_we, be: core_be, addr: core_addr, wdata: core_wdata};
  assign fab_r  = '{we: fab_we,  be: fab_be,  addr: fab_addr,  wdata: fab_wdata};

  // Grants are suppressed during reset and the cycle after it.
  assign gnt_en   = !rst && !rst_d;
  assign fab_pri  = (wait_cnt == WAIT_SAT);
  assign fab_win  = gnt_en && fab_req && (fab_pri || !core_req);
  assign core_win = gnt_en && core_req && !fab_win;
  assign gnt_any  = core_win || fab_win;
  assign core_gnt = core_win;
  assign fab_gnt  = fab_win;

  assign sel      = fab_win ? fab_r : core_r;
  assign sel_port = fab_win ? PORT_FAB : PORT_CORE;

  // Offsets wrap below each base, so a single unsigned compare bounds each region.
  assign addr_w    = sel.addr & 32'hFFFF_FFFC;
  assign data_off  = addr_w - DATA_BASE;
  assign mmio_word = addr_w[31:2] - MMIO_BASE[31:2];
  assign data_hit  = data_off < DATA_BYTES;
  assign mmio_hit  = !data_hit && (mmio_word < 30'(NUM_MMIO));
  assign region    = data_hit ? REG_DATA : (mmio_hit ? REG_MMIO : REG_UNMAP);

  always_comb begin
    mmio_rd = '0;
    for (int i = 0; i < NUM_CR; i++)
      if (mmio_word == 30'(i)) mmio_rd = cr_q[i];
    for (int j = 0; j < NUM_DRCT; j++)
      if (mmio_word == 30'(NUM_CR + j)) mmio_rd = drct_q[j];
  end

  always_ff @(posedge clock) rst_d <= rst;

  always_ff @(posedge clock) begin
    if (rst)                                 wait_cnt <= '0;
    else if (fab_win)                        wait_cnt <= '0;
    else if (fab_req && wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + WCW'(1);
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CR; i++) begin
      if (rst)
        cr_q[i] <= CR_RST_VAL[32*i +: 32];
      else if (gnt_any && sel.we && region == REG_MMIO && mmio_word == 30'(i))
        cr_q[i] <= be_merge(cr_q[i], sel.wdata, sel.be);
    end
    for (int j = 0; j < NUM_DRCT; j++) begin
      if (rst)
        drct_q[j] <= '0;
      else if (gnt_any && sel.we && region == REG_MMIO && mmio_word == 30'(NUM_CR + j))
        drct_q[j] <= be_merge(drct_q[j], sel.wdata, sel.be);
    end
  end

  assign cr_o       = cr_q;
  assign drct_out_o = drct_q;

  gpc_sram_sp_be #(.DEPTH(DATA_DEPTH)) u_sram (
    .clock (clock),
    .en    (gnt_any && region == REG_DATA),
    .we    (sel.we),
    .be    (sel.be),
    .addr  (data_off[AW+1:2]),
    .wdata (sel.wdata),
    .q     (sram_q)
  );

  // Response pipe: region tag and port id pick the source when rvalid fires.
  always_ff @(posedge clock) begin
    if (rst) begin
      rvalid_q  <= 1'b0;
      rwe_q     <= 1'b0;
      rport_q   <= PORT_CORE;
      rregion_q <= REG_UNMAP;
      mmio_q    <= '0;
    end else begin
      rvalid_q <= gnt_any;
      if (gnt_any) begin
        rwe_q     <= sel.we;
        rport_q   <= sel_port;
        rregion_q <= region;
        mmio_q    <= mmio_rd;
      end
    end
  end

  always_comb begin
    rsp_data = '0;
    if (!rwe_q) begin
      case (rregion_q)
        REG_DATA: rsp_data = sram_q;
        REG_MMIO: rsp_data = mmio_q;
        default:  rsp_data = '0;
      endcase
    end
  end

  assign rsp_live    = rvalid_q && !rst;
  assign core_rvalid = rsp_live && rport_q == PORT_CORE;
  assign fab_rvalid  = rsp_live && rport_q == PORT_FAB;
  assign core_rdata  = core_rvalid ? rsp_data : '0;
  assign fab_rdata   = fab_rvalid  ? rsp_data : '0;
  assign core_err    = core_rvalid && rregion_q == REG_UNMAP;
  assign fab_err     = fab_rvalid  && rregion_q == REG_UNMAP;

endmodule

// File: tb/tb_gpc_dmem_mmio_arb.sv
// Directed bench for gpc_dmem_mmio_arb: a map/arbitration model checked every
// cycle on the falling edge, plus hand-computed literal expectations.
module tb_gpc_dmem_mmio_arb;

  localparam int NUM_CR = 8, NUM_DRCT = 2, STARVE = 4, DEPTH = 512;
  localparam logic [NUM_CR*32-1:0] CRV = {32'hC7C7C7C7, 32'hC6C6C6C6, 32'hC5C5C5C5,
    32'hC4C4C4C4, 32'hC3C3C3C3, 32'h11223344, 32'hC1C1C1C1, 32'hC0C0C0C0};

  logic clock, rst;
  logic core_req, core_we, core_gnt, core_rvalid, core_err;
  logic [3:0] core_be;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic fab_req, fab_we, fab_gnt, fab_rvalid, fab_err;
  logic [3:0] fab_be;
  logic [31:0] fab_addr, fab_wdata, fab_rdata;
  logic [NUM_CR*32-1:0] cr_o;
  logic [NUM_DRCT*32-1:0] drct_out_o;

  int checks = 0, errors = 0;

  gpc_dmem_mmio_arb #(
    .DATA_DEPTH(DEPTH), .DATA_BASE(32'h0), .MMIO_BASE(32'h1000), .NUM_CR(NUM_CR),
    .NUM_DRCT(NUM_DRCT), .CR_RST_VAL(CRV), .STARVE_MAX(STARVE)
  ) dut (
    .clock(clock), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_be(core_be), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata), .core_err(core_err),
    .fab_req(fab_req), .fab_we(fab_we), .fab_be(fab_be), .fab_addr(fab_addr),
    .fab_wdata(fab_wdata), .fab_gnt(fab_gnt), .fab_rvalid(fab_rvalid),
    .fab_rdata(fab_rdata), .fab_err(fab_err),
    .cr_o(cr_o), .drct_out_o(drct_out_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_cr [NUM_CR];
  logic [31:0] m_drct [NUM_DRCT];
  logic [31:0] m_mem [int];
  int          m_starve;
  bit          m_rst_prev = 1'b1;
  bit          p_vld, p_fab, p_err;
  logic [31:0] p_data;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CR; i++) m_cr[i] = CRV[32*i +: 32];
    for (int j = 0; j < NUM_DRCT; j++) m_drct[j] = 32'h0;
    m_starve = 0;
    p_vld = 1'b0;
  endtask

  task automatic model_access(input bit is_fab, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] a;
    int k;
    a = addr & 32'hFFFF_FFFC;
    p_vld = 1'b1; p_fab = is_fab; p_data = 32'h0; p_err = 1'b0;
    if (a < 32'(4 * DEPTH)) begin
      k = int'(a >> 2);
      if (we) m_mem[k] = merge(m_mem.exists(k) ? m_mem[k] : 32'h0, wdata, be);
      else    p_data = m_mem.exists(k) ? m_mem[k] : 32'h0;
    end else if (a >= 32'h1000 && a < 32'h1000 + 32'(4 * (NUM_CR + NUM_DRCT))) begin
      k = int'((a - 32'h1000) >> 2);
      if (k < NUM_CR) begin
        if (we) m_cr[k] = merge(m_cr[k], wdata, be); else p_data = m_cr[k];
      end else begin
        if (we) m_drct[k-NUM_CR] = merge(m_drct[k-NUM_CR], wdata, be);
        else    p_data = m_drct[k-NUM_CR];
      end
    end else begin
      p_err = 1'b1;
    end
  endtask

  always @(negedge clock) begin : cmp
    bit en, fw, ecg, efg, ecv, efv;
    en  = !rst && !m_rst_prev;
    fw  = fab_req && (m_starve >= STARVE || !core_req);
    ecg = en && core_req && !fw;
    efg = en && fab_req && fw;
    ecv = !rst && p_vld && !p_fab;
    efv = !rst && p_vld && p_fab;
    chk("core_gnt", core_gnt, ecg);
    chk("fab_gnt", fab_gnt, efg);
    chk("core_rvalid", core_rvalid, ecv);
    chk("fab_rvalid", fab_rvalid, efv);
    if (ecv || rst || m_rst_prev) begin
      chk("core_rdata", core_rdata, ecv ? p_data : 32'h0);
      chk("core_err", core_err, ecv && p_err);
    end
    if (efv || rst || m_rst_prev) begin
      chk("fab_rdata", fab_rdata, efv ? p_data : 32'h0);
      chk("fab_err", fab_err, efv && p_err);
    end
    for (int i = 0; i < NUM_CR; i++)
      chk($sformatf("cr_o[%0d]", i), cr_o[32*i +: 32], m_cr[i]);
    for (int j = 0; j < NUM_DRCT; j++)
      chk($sformatf("drct_out_o[%0d]", j), drct_out_o[32*j +: 32], m_drct[j]);
    // advance the model to what the next rising edge must produce
    if (rst) begin
      model_reset();
    end else begin
      p_vld = 1'b0;
      if (ecg)      model_access(1'b0, core_we, core_be, core_addr, core_wdata);
      else if (efg) model_access(1'b1, fab_we, fab_be, fab_addr, fab_wdata);
      if (efg)                              m_starve = 0;
      else if (fab_req && m_starve < STARVE) m_starve++;
    end
    m_rst_prev = rst;
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_wdata = 0;
    fab_req = 0; fab_we = 0; fab_be = 0; fab_addr = 0; fab_wdata = 0;
  endtask

  task automatic core_acc(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata);
    idle();
    core_req = 1; core_we = we; core_be = be; core_addr = addr; core_wdata = wdata;
  endtask

  task automatic fab_acc(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata);
    idle();
    fab_req = 1; fab_we = we; fab_be = be; fab_addr = addr; fab_wdata = wdata;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clock);
    #1;
    rst = 1'b0;

    core_acc(0, 4'h0, 32'h10, 32'h0);
    #1 chk("gnt_cycle_after_rst", core_gnt, 1'b0);
    step();
    chk("rst_cr2", cr_o[95:64], 32'h11223344);
    chk("rst_drct", drct_out_o, 64'h0);
    chk("rst_rvalid", core_rvalid, 1'b0);

    core_acc(1, 4'hF, 32'h10, 32'hDEADBEEF); step();
    chk("wr_rvalid", core_rvalid, 1'b1);
    chk("wr_rdata", core_rdata, 32'h0);
    core_acc(0, 4'h0, 32'h10, 32'h0); step();
    chk("rd_rvalid", core_rvalid, 1'b1);
    chk("rd_rdata", core_rdata, 32'hDEADBEEF);
    chk("rd_err", core_err, 1'b0);

    fab_acc(1, 4'b0010, 32'h1008, 32'h0000AB00); step();
    chk("cr2_byte_wr", cr_o[95:64], 32'h1122AB44);
    chk("cr2_wr_rvalid", fab_rvalid, 1'b1);
    core_acc(0, 4'h0, 32'h1008, 32'h0); step();
    chk("cr2_rd", core_rdata, 32'h1122AB44);

    core_acc(0, 4'h0, 32'h2000, 32'h0); step();
    chk("unmap_rd_rvalid", core_rvalid, 1'b1);
    chk("unmap_rd_err", core_err, 1'b1);
    chk("unmap_rd_rdata", core_rdata, 32'h0);

    fab_acc(1, 4'hF, 32'h2004, 32'hFFFFFFFF); step();
    chk("unmap_wr_err", fab_err, 1'b1);
    fab_acc(1, 4'hF, 32'h0800, 32'hFFFFFFFF); step();
    chk("data_end_err", fab_err, 1'b1);
    fab_acc(1, 4'hF, 32'h1028, 32'hFFFFFFFF); step();
    chk("mmio_end_err", fab_err, 1'b1);

    core_acc(1, 4'hF, 32'h7FC, 32'hA5A50001); step();
    chk("last_word_err", core_err, 1'b0);
    core_acc(0, 4'h0, 32'h7FE, 32'h0); step();
    chk("last_word_rd", core_rdata, 32'hA5A50001);

    core_acc(1, 4'hF, 32'h1024, 32'h12345678); step();
    chk("drct1_wr", drct_out_o[63:32], 32'h12345678);
    core_acc(1, 4'b1100, 32'h1023, 32'hCAFE0000); step();
    chk("drct0_be_wr", drct_out_o[31:0], 32'hCAFE0000);

    core_acc(1, 4'hF, 32'h40, 32'h1); step();
    core_acc(1, 4'hF, 32'h40, 32'h2); step();
    core_acc(0, 4'h0, 32'h40, 32'h0); step();
    chk("b2b_core_rd", core_rdata, 32'h2);
    fab_acc(0, 4'h0, 32'h40, 32'h0); step();
    chk("b2b_fab_rvalid", fab_rvalid, 1'b1);
    chk("b2b_fab_rd", fab_rdata, 32'h2);

    // both requesting every cycle: four core grants then one fabric grant
    core_acc(0, 4'h0, 32'h10, 32'h0);
    fab_req = 1; fab_we = 0; fab_be = 0; fab_addr = 32'h40; fab_wdata = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("starve_core_gnt[%0d]", c), core_gnt, (c % 5) != 4);
      chk($sformatf("starve_fab_gnt[%0d]", c), fab_gnt, (c % 5) == 4);
      step();
    end
    idle(); step();

    // reset during a response cycle kills it and restores the register bank
    core_acc(0, 4'h0, 32'h10, 32'h0); step();
    idle(); rst = 1'b1;
    #1 chk("rst_kills_rvalid", core_rvalid, 1'b0);
    step();
    for (int i = 0; i < NUM_CR; i++) chk("rst_cr_bank", cr_o[32*i +: 32], CRV[32*i +: 32]);
    chk("rst_drct_clear", drct_out_o, 64'h0);
    rst = 1'b0; step(); step();
    core_acc(0, 4'h0, 32'h10, 32'h0); step();
    chk("sram_survives_rst", core_rdata, 32'hDEADBEEF);

    // reset asserted in the would-be grant cycle
    core_acc(0, 4'h0, 32'h40, 32'h0); rst = 1'b1;
    #1 chk("rst_blocks_gnt", core_gnt, 1'b0);
    step();
    chk("rst_no_rvalid", core_rvalid, 1'b0);
    rst = 1'b0; idle(); step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
